// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two WIDTH-bit operands one nibble per clock through a
// single shared 4-bit ripple adder, chaining the carry LSB nibble to MSB nibble.
`default_nettype none

module Adder_4Bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out
);
  logic [4:0] sum;

  assign sum   = {1'b0, A} + {1'b0, B} + {4'b0000, C_in};
  assign S     = sum[3:0];
  assign C_out = sum[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S_out,
  output logic             C_out,
  output logic             V_out
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] nib_sum;
  logic       nib_cout;

  // Select the operand nibbles addressed by the nibble counter.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  Adder_4Bit u_adder (
    .A     (a_nib),
    .B     (b_nib),
    .C_in  (carry),
    .S     (nib_sum),
    .C_out (nib_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S_out <= '0;
      C_out <= 1'b0;
      V_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A_in;
            b_reg <= B_in;
            carry <= C_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
              S_out[4*i +: 4] <= nib_sum;
            end
          end
          carry <= nib_cout;
          // Final nibble: its MSBs decide signed overflow.
          if (cnt == LAST) begin
            C_out <= nib_cout;
            V_out <= (a_nib[3] == b_nib[3]) && (nib_sum[3] != a_nib[3]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl at WIDTH=16: stimulus queues expected
// results, a negedge monitor checks every done pulse against them.
`default_nettype none

module tb_nibble_serial_add_ctrl;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A_in;
  logic [15:0] B_in;
  logic        C_in;
  logic        busy;
  logic        done;
  logic [15:0] S_out;
  logic        C_out;
  logic        V_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          acc;
  } exp_t;

  exp_t q[$];

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A_in  (A_in),
    .B_in  (B_in),
    .C_in  (C_in),
    .busy  (busy),
    .done  (done),
    .S_out (S_out),
    .C_out (C_out),
    .V_out (V_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each done pulse pops one expected result.
  initial begin
    exp_t e;
    int   busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
          end else begin
            e = q.pop_front();
            check("sum",      32'(S_out), 32'(e.s));
            check("carry",    32'(C_out), 32'(e.c));
            check("overflow", 32'(V_out), 32'(e.v));
            check("latency",  32'(cyc - e.acc), 32'd4);
            check("busy_len", 32'(busy_cnt), 32'd4);
          end
          busy_cnt = 0;
        end else if (busy) begin
          busy_cnt++;
        end else begin
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 10 cycles expected a pulse");
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input logic ev);
    A_in  = a;
    B_in  = b;
    C_in  = c;
    start = 1'b1;
    q.push_back('{es, ec, ev, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    A_in  = 16'($urandom);
    B_in  = 16'($urandom);
    C_in  = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int acc0;
    int got;
    int dc[3];

    rst   = 1'b1;
    start = 1'b0;
    A_in  = '0;
    B_in  = '0;
    C_in  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy),  32'd0);
    check("rst_done", 32'(done),  32'd0);
    check("rst_sum",  32'(S_out), 32'd0);
    check("rst_c",    32'(C_out), 32'd0);
    check("rst_v",    32'(V_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Start pulses during RUN and DONE must be dropped.
    A_in  = 16'h1234;
    B_in  = 16'h1111;
    C_in  = 1'b0;
    start = 1'b1;
    q.push_back('{16'h2345, 1'b0, 1'b0, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A_in  = 16'hFFFF;
    B_in  = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignore_done_busy", 32'(busy), 32'd0);
    check("ignore_done_done", 32'(done), 32'd0);
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // Reset pulse after two nibbles aborts the operation.
    A_in  = 16'hFFFF;
    B_in  = 16'hFFFF;
    C_in  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy),  32'd0);
    check("abort_done", 32'(done),  32'd0);
    check("abort_sum",  32'(S_out), 32'd0);
    check("abort_c",    32'(C_out), 32'd0);
    check("abort_v",    32'(V_out), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    run_op(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // start held high: back-to-back ops, one idle cycle between DONE and next accept.
    A_in  = 16'hFFFF;
    B_in  = 16'hFFFF;
    C_in  = 1'b1;
    start = 1'b1;
    acc0  = cyc + 1;
    q.push_back('{16'hFFFF, 1'b1, 1'b0, acc0});
    q.push_back('{16'hFFFF, 1'b1, 1'b0, acc0 + 6});
    q.push_back('{16'hFFFF, 1'b1, 1'b0, acc0 + 12});
    got = 0;
    for (int n = 0; n < 40 && got < 3; n++) begin
      @(negedge clk);
      if (done) begin
        dc[got] = cyc;
        got++;
      end
    end
    start = 1'b0;
    check("held_count", 32'(got), 32'd3);
    if (got == 3) begin
      // Five clocks separate consecutive done pulses: an interval of six edges.
      check("held_gap1", 32'(dc[1] - dc[0]), 32'd6);
      check("held_gap2", 32'(dc[2] - dc[1]), 32'd6);
    end
    repeat (4) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
